// File: rtl/pe_seq_ctrl.sv
// Sequencer for a multiply-accumulate PE: feeds a job of operand pairs, pulses the
// format strobe, waits out the PE latency and holds the captured result for the consumer.
module pe_seq_ctrl #(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_LEN  = 8,
  parameter int PE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [WIDTH_LEN-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH_DATA-1:0] a_i,
  input  logic [WIDTH_DATA-1:0] b_i,
  output logic [WIDTH_DATA-1:0] pe_a_o,
  output logic [WIDTH_DATA-1:0] pe_b_o,
  output logic                  pe_keep_o,
  output logic                  pe_format_o,
  input  logic [WIDTH_DATA-1:0] pe_data_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [WIDTH_DATA-1:0] res_data_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FORMAT,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [WIDTH_LEN-1:0] LP_CNT_ONE   = WIDTH_LEN'(1);
  localparam logic [3:0]           LP_WAIT_LAST = 4'(PE_LATENCY - 1);

  state_t                r_state, w_state;
  logic [WIDTH_LEN-1:0]  r_len, w_len;
  logic [WIDTH_LEN-1:0]  r_cnt, w_cnt;
  logic [WIDTH_LEN-1:0]  w_cnt_inc;
  logic [3:0]            r_wcnt, w_wcnt;
  logic [WIDTH_DATA-1:0] r_pe_a, w_pe_a;
  logic [WIDTH_DATA-1:0] r_pe_b, w_pe_b;
  logic                  r_keep, w_keep;
  logic                  r_format, w_format;
  logic                  r_res_valid, w_res_valid;
  logic [WIDTH_DATA-1:0] r_res_data, w_res_data;
  logic                  r_done, w_done;

  assign w_cnt_inc = r_cnt + LP_CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_pe_a      <= '0;
      r_pe_b      <= '0;
      r_keep      <= 1'b0;
      r_format    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_len       <= w_len;
      r_cnt       <= w_cnt;
      r_wcnt      <= w_wcnt;
      r_pe_a      <= w_pe_a;
      r_pe_b      <= w_pe_b;
      r_keep      <= w_keep;
      r_format    <= w_format;
      r_res_valid <= w_res_valid;
      r_res_data  <= w_res_data;
      r_done      <= w_done;
    end
  end

  // PE-side outputs are registered, so they show the decision made in a state
  // during the cycle after it; the keep flag clears only on the first beat of a job.
  always_comb begin
    w_state     = r_state;
    w_len       = r_len;
    w_cnt       = r_cnt;
    w_wcnt      = r_wcnt;
    w_pe_a      = '0;
    w_pe_b      = '0;
    w_keep      = 1'b0;
    w_format    = 1'b0;
    w_res_valid = r_res_valid;
    w_res_data  = r_res_data;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && (len_i != '0)) begin
          w_state = S_FEED;
          w_len   = len_i;
          w_cnt   = '0;
        end
      end
      S_FEED: begin
        w_keep = (r_cnt != '0);
        if (in_valid_i) begin
          w_pe_a = a_i;
          w_pe_b = b_i;
          w_cnt  = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_state = S_FORMAT;
          end
        end
      end
      S_FORMAT: begin
        w_format = 1'b1;
        w_keep   = 1'b1;
        w_wcnt   = '0;
        w_state  = S_WAIT;
      end
      S_WAIT: begin
        w_keep = 1'b1;
        if (r_wcnt == LP_WAIT_LAST) begin
          w_res_data  = pe_data_i;
          w_res_valid = 1'b1;
          w_state     = S_HOLD;
        end else begin
          w_wcnt = r_wcnt + 4'd1;
        end
      end
      S_HOLD: begin
        if (res_ready_i) begin
          w_res_valid = 1'b0;
          w_done      = 1'b1;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign busy_o      = (r_state != S_IDLE);
  assign in_ready_o  = (r_state == S_FEED);
  assign done_o      = r_done;
  assign pe_a_o      = r_pe_a;
  assign pe_b_o      = r_pe_b;
  assign pe_keep_o   = r_keep;
  assign pe_format_o = r_format;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with a behavioural MAC PE whose output is only
// valid after it has sampled the format strobe.
module tb_pe_seq_ctrl;
  localparam int WD  = 16;
  localparam int WL  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [WL-1:0] len_i = '0;
  logic          busy_o, done_o;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [WD-1:0] a_i = '0;
  logic [WD-1:0] b_i = '0;
  logic [WD-1:0] pe_a_o, pe_b_o;
  logic          pe_keep_o, pe_format_o;
  logic [WD-1:0] pe_data_i;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [WD-1:0] res_data_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pe_seq_ctrl #(.WIDTH_DATA(WD), .WIDTH_LEN(WL), .PE_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .pe_a_o     (pe_a_o),
    .pe_b_o     (pe_b_o),
    .pe_keep_o  (pe_keep_o),
    .pe_format_o(pe_format_o),
    .pe_data_i  (pe_data_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o (res_data_o)
  );

  always #5 clk = ~clk;

  // Behavioural PE: accumulate a*b (restart when keep=0), publish after format.
  logic [WD-1:0] pe_acc = '0;
  logic          pe_ok = 1'b0;
  always @(posedge clk) begin
    if (!pe_format_o) pe_acc <= (pe_keep_o ? pe_acc : '0) + pe_a_o * pe_b_o;
    pe_ok <= pe_format_o ? 1'b1 : (pe_keep_o ? pe_ok : 1'b0);
  end
  assign pe_data_i = pe_ok ? pe_acc : 16'hDEAD;

  function automatic logic [63:0] outs();
    return {10'd0, busy_o, done_o, in_ready_o, pe_a_o, pe_b_o, pe_keep_o,
            pe_format_o, res_valid_o, res_data_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_res(input string tag);
    int unsigned n = 0;
    while (!res_valid_o && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_res_valid"}, 64'(res_valid_o), 64'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_outs", outs(), 64'd0);
    rst_n = 1'b1;

    // Job 1: len=4, in_valid held, start honoured on first edge after reset
    start_i = 1'b1; len_i = 8'd4; in_valid_i = 1'b1; a_i = 16'd1; b_i = 16'd1;
    tick();
    chk("j1_busy", 64'(busy_o), 64'd1);
    chk("j1_ready", 64'(in_ready_o), 64'd1);
    chk("j1_idle_keep", 64'(pe_keep_o), 64'd0);
    start_i = 1'b0;
    tick();
    chk("j1_b1_a", 64'(pe_a_o), 64'd1);
    chk("j1_b1_keep", 64'(pe_keep_o), 64'd0);
    a_i = 16'd2; b_i = 16'd2;
    tick();
    chk("j1_b2_b", 64'(pe_b_o), 64'd2);
    chk("j1_b2_keep", 64'(pe_keep_o), 64'd1);
    a_i = 16'd3; b_i = 16'd3;
    tick();
    chk("j1_b3_a", 64'(pe_a_o), 64'd3);
    chk("j1_b3_keep", 64'(pe_keep_o), 64'd1);
    a_i = 16'd4; b_i = 16'd4;
    tick();
    chk("j1_b4_a", 64'(pe_a_o), 64'd4);
    chk("j1_b4_keep", 64'(pe_keep_o), 64'd1);
    chk("j1_b4_ready", 64'(in_ready_o), 64'd0);
    chk("j1_b4_fmt", 64'(pe_format_o), 64'd0);
    in_valid_i = 1'b0; a_i = '0; b_i = '0;
    tick();
    chk("j1_fmt", 64'(pe_format_o), 64'd1);
    chk("j1_fmt_a", 64'(pe_a_o), 64'd0);
    chk("j1_fmt_keep", 64'(pe_keep_o), 64'd1);
    tick();
    chk("j1_fmt_end", 64'(pe_format_o), 64'd0);
    chk("j1_wait_nores", 64'(res_valid_o), 64'd0);
    tick();
    chk("j1_res_valid", 64'(res_valid_o), 64'd1);
    chk("j1_res_data", 64'(res_data_o), 64'd30);
    res_ready_i = 1'b1;
    tick();
    chk("j1_done", 64'(done_o), 64'd1);
    chk("j1_res_clr", 64'(res_valid_o), 64'd0);
    chk("j1_idle_busy", 64'(busy_o), 64'd0);
    res_ready_i = 1'b0;
    tick();
    chk("j1_done_pulse", 64'(done_o), 64'd0);

    // Job 2: len=3 with in_valid toggling 1,0,1,0,1; then a 5-cycle HOLD stall
    start_i = 1'b1; len_i = 8'd3; in_valid_i = 1'b1; a_i = 16'd1; b_i = 16'd1;
    tick();
    start_i = 1'b0;
    tick();
    chk("j2_b1_a", 64'(pe_a_o), 64'd1);
    chk("j2_b1_keep", 64'(pe_keep_o), 64'd0);
    in_valid_i = 1'b0; a_i = 16'd9; b_i = 16'd9;
    tick();
    chk("j2_gap1_ops", {pe_a_o, pe_b_o}, 64'd0);
    chk("j2_gap1_keep", 64'(pe_keep_o), 64'd1);
    in_valid_i = 1'b1; a_i = 16'd2; b_i = 16'd2;
    tick();
    chk("j2_b2_a", 64'(pe_a_o), 64'd2);
    in_valid_i = 1'b0;
    tick();
    chk("j2_gap2_ops", {pe_a_o, pe_b_o}, 64'd0);
    chk("j2_gap2_keep", 64'(pe_keep_o), 64'd1);
    chk("j2_gap2_ready", 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b1; a_i = 16'd3; b_i = 16'd3;
    tick();
    chk("j2_b3_a", 64'(pe_a_o), 64'd3);
    chk("j2_b3_ready", 64'(in_ready_o), 64'd0);
    in_valid_i = 1'b0;
    tick();
    tick();
    tick();
    chk("j2_res_valid", 64'(res_valid_o), 64'd1);
    chk("j2_res_data", 64'(res_data_o), 64'd14);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("j2_stall", {res_valid_o, done_o, res_data_o}, {1'b1, 1'b0, 16'd14});
    end
    res_ready_i = 1'b1;
    tick();
    chk("j2_done", {done_o, res_valid_o}, 64'b10);
    res_ready_i = 1'b0;
    tick();
    chk("j2_done_pulse", 64'(done_o), 64'd0);

    // Job 3: len=0 ignored, start during FEED ignored, reset during WAIT
    start_i = 1'b1; len_i = 8'd0;
    tick();
    chk("j3_len0", {busy_o, done_o}, 64'd0);
    start_i = 1'b0;
    tick();
    chk("j3_len0_after", {busy_o, done_o}, 64'd0);
    start_i = 1'b1; len_i = 8'd2; in_valid_i = 1'b1; a_i = 16'd2; b_i = 16'd2;
    tick();
    len_i = 8'd5;
    tick();
    chk("j3_b1_a", 64'(pe_a_o), 64'd2);
    a_i = 16'd3; b_i = 16'd3;
    tick();
    chk("j3_no_extra", 64'(in_ready_o), 64'd0);
    start_i = 1'b0; in_valid_i = 1'b0;
    tick();
    chk("j3_fmt", 64'(pe_format_o), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("j3_rst_outs", outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("j3_post_rst1", {busy_o, done_o, res_valid_o}, 64'd0);
    tick();
    chk("j3_post_rst2", {busy_o, done_o, res_valid_o}, 64'd0);
    start_i = 1'b1; len_i = 8'd1; in_valid_i = 1'b1; a_i = 16'd5; b_i = 16'd5;
    tick();
    chk("j3_new_busy", 64'(busy_o), 64'd1);
    start_i = 1'b0;
    tick();
    chk("j3_new_beat", {pe_a_o, pe_b_o, pe_keep_o}, {16'd5, 16'd5, 1'b0});
    in_valid_i = 1'b0;
    wait_res("j3");
    chk("j3_res_data", 64'(res_data_o), 64'd25);
    res_ready_i = 1'b1;
    tick();
    chk("j3_done", 64'(done_o), 64'd1);
    res_ready_i = 1'b0;
    tick();

    // Job 4: len=255, then a second job started in the done cycle
    start_i = 1'b1; len_i = 8'd255; in_valid_i = 1'b1; a_i = 16'd1; b_i = 16'd1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i == 1) chk("j4_first_keep", {pe_a_o, pe_keep_o}, {16'd1, 1'b0});
      if (i == 254) chk("j4_ready_254", 64'(in_ready_o), 64'd1);
      if (i == 255) chk("j4_ready_255", 64'(in_ready_o), 64'd0);
    end
    in_valid_i = 1'b0;
    wait_res("j4");
    chk("j4_res_data", 64'(res_data_o), 64'd255);
    res_ready_i = 1'b1;
    tick();
    chk("j4_done", 64'(done_o), 64'd1);
    res_ready_i = 1'b0;
    start_i = 1'b1; len_i = 8'd1; in_valid_i = 1'b1; a_i = 16'd3; b_i = 16'd3;
    tick();
    chk("j5_b2b_start", {busy_o, in_ready_o, done_o}, 64'b110);
    start_i = 1'b0;
    tick();
    chk("j5_first_beat", {pe_a_o, pe_keep_o}, {16'd3, 1'b0});
    in_valid_i = 1'b0;
    wait_res("j5");
    chk("j5_res_data", 64'(res_data_o), 64'd9);
    res_ready_i = 1'b1;
    tick();
    chk("j5_done", 64'(done_o), 64'd1);
    res_ready_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001: Parameter WIDTH_DATA, default 16, operand and result width.
REQ-002: Parameter WIDTH_LEN, default 8, job-length field width.
REQ-003: Parameter PE_LATENCY, default 2, cycles from pe_format_o sample to valid pe_data_i (legal range 1..15).
REQ-004: The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005: Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start_i  in  1  job start request
- len_i  in  WIDTH_LEN  operand pairs in job
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-complete pulse
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  operand pair accepted
- a_i, b_i  in  WIDTH_DATA each  operand pair
- pe_a_o, pe_b_o  out  WIDTH_DATA each  to PE data_a/data_b
- pe_keep_o  out  1  to PE keep_data
- pe_format_o  out  1  to PE format_en
- pe_data_i  in  WIDTH_DATA  from PE data_o
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted
- res_data_o  out  WIDTH_DATA  captured result

Function
REQ-006: The FSM SHALL have states IDLE, FEED, FORMAT, WAIT, HOLD; all pe_* and res_* outputs SHALL be registered.
REQ-007: In IDLE, start_i=1 with len_i!=0 SHALL latch len_i, clear beat count, and go to FEED next cycle; start_i with len_i=0 SHALL be ignored (no busy, no done).
REQ-008: start_i SHALL be ignored in every state except IDLE.
REQ-009: busy_o SHALL be 1 in FEED, FORMAT, WAIT, HOLD, and 0 in IDLE.
REQ-010: in_ready_o SHALL be 1 only in FEED; a beat is accepted when in_valid_i and in_ready_o are both 1 at a rising edge.
REQ-011: On an accepted beat, pe_a_o/pe_b_o SHALL take a_i/b_i at that edge (one-cycle latency); on any FEED cycle without an accepted beat they SHALL be zero.
REQ-012: pe_keep_o SHALL be 0 on the cycle carrying the first accepted beat of a job (accumulator clear) and 1 on every later cycle of FEED, FORMAT, and WAIT; in IDLE and HOLD it SHALL be 0.
REQ-013: The beat count SHALL increment per accepted beat; the beat making count equal to the latched length SHALL move FSM to FORMAT at the same edge.
REQ-014: FORMAT SHALL last exactly one cycle with pe_format_o=1, operands zero, then go to WAIT; pe_format_o SHALL be 0 in all other states.
REQ-015: WAIT SHALL last PE_LATENCY cycles; on its final edge res_data_o SHALL capture pe_data_i, res_valid_o SHALL rise, FSM goes to HOLD.
REQ-016: In HOLD, res_valid_o and res_data_o SHALL stay stable until res_ready_i=1 at an edge; at that edge res_valid_o clears, done_o pulses high for the following cycle, FSM returns to IDLE.
REQ-017: A start_i in the cycle done_o is high SHALL be accepted (back-to-back jobs); no bubble other than the IDLE cycle is required.
REQ-018: len_i=2^WIDTH_LEN-1 SHALL be supported without count wrap; the count register SHALL be WIDTH_LEN bits and compare for equality.

Reset
REQ-019: rst_n=0 SHALL immediately force IDLE, count=0, and all outputs 0 (busy_o, done_o, in_ready_o, pe_a_o, pe_b_o, pe_keep_o, pe_format_o, res_valid_o, res_data_o), including mid-job; no done_o follows a reset-aborted job.
REQ-020: After rst_n deasserts, the first start_i SHALL be honoured on the first rising edge.

Verification
REQ-021: len=4, pairs (1,1),(2,2),(3,3),(4,4) with in_valid_i held 1 -> pe_keep_o pattern 0,1,1,1; single pe_format_o pulse one cycle after last beat; res_valid_o after PE_LATENCY cycles with res_data_o = PE output (30 with a real PE).
REQ-022: len=3 with in_valid_i toggling 1,0,1,0,1 -> exactly 3 beats accepted, zero operands and pe_keep_o=1 on gap cycles, result identical to the gap-free run.
REQ-023: res_ready_i held 0 for 5 cycles in HOLD -> res_valid_o/res_data_o stable 5 cycles, done_o pulses once, one cycle after res_ready_i rises.
REQ-024: start_i with len_i=0, and start_i asserted during FEED -> no state change, no done_o, no extra beats.
REQ-025: rst_n pulsed low during WAIT -> all outputs 0 asynchronously, no res_valid_o/done_o; new len=1 job (5,5) then completes normally.
REQ-026: len=255 back-to-back with a second start in the done_o cycle -> 255 beats, no count wrap, second job starts with pe_keep_o=0 on its first beat.
